// File: rtl/channel_history.sv
// channel_history: per-channel epoch history and I^2+Q^2 pre-processing ahead of the tracking
// loops. One shared multiplier squares the six captured E/P/L I/Q terms over six cycles.
// Optional build macro: CHANNEL_HISTORY_SKIP_FIRST_EN (first epoch after reset only primes the
// k-1 history and does not emit i2q2_valid).

module channel_history #(
    parameter int unsigned ACC_WIDTH      = 16,
    parameter int unsigned IQ_WIDTH       = 17,
    parameter int unsigned W_DF_WIDTH     = 27,
    parameter int unsigned W_DF_DOT_WIDTH = 27,
    localparam int unsigned I2Q2_WIDTH    = 2 * ACC_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    // Epoch accumulations
    input  logic                             acc_valid,
    input  logic signed [ACC_WIDTH-1:0]      i_early,
    input  logic signed [ACC_WIDTH-1:0]      q_early,
    input  logic signed [ACC_WIDTH-1:0]      i_prompt,
    input  logic signed [ACC_WIDTH-1:0]      q_prompt,
    input  logic signed [ACC_WIDTH-1:0]      i_late,
    input  logic signed [ACC_WIDTH-1:0]      q_late,
    output logic                             acc_dropped,
    output logic                             busy,
    // Towards the tracking loops
    output logic                             i2q2_valid,
    output logic [I2Q2_WIDTH-1:0]            i2q2_early_k,
    output logic [I2Q2_WIDTH-1:0]            i2q2_prompt_k,
    output logic [I2Q2_WIDTH-1:0]            i2q2_late_k,
    output logic signed [ACC_WIDTH-1:0]      i_prompt_k,
    output logic signed [ACC_WIDTH-1:0]      q_prompt_k,
    output logic signed [ACC_WIDTH-1:0]      i_prompt_km1,
    output logic signed [ACC_WIDTH-1:0]      q_prompt_km1,
    output logic [IQ_WIDTH-1:0]              iq_prompt_km1,
    output logic signed [W_DF_WIDTH-1:0]     w_df_k,
    output logic signed [W_DF_DOT_WIDTH-1:0] w_df_dot_k,
    // Results returned by the tracking loops
    input  logic                             tracking_ready,
    input  logic [IQ_WIDTH-1:0]              iq_prompt_k_in,
    input  logic signed [W_DF_WIDTH-1:0]     w_df_kp1,
    input  logic signed [W_DF_DOT_WIDTH-1:0] w_df_dot_kp1
);

    typedef enum logic [1:0] {
        StIdle,
        StSquare,
        StValid,
        StWait
    } state_e;

    localparam logic [2:0] LastStep = 3'd5;

    state_e state_q, state_d;
    logic [2:0] step_q, step_d;

    // Control decoded from the current state
    logic capture;
    logic square_en;
    logic absorb;
    logic drop;
    logic emit;

    // Capture registers for the epoch being squared
    logic signed [ACC_WIDTH-1:0] cap_ie_q, cap_qe_q, cap_ip_q, cap_qp_q, cap_il_q, cap_ql_q;

    // Shared squarer
    logic signed [ACC_WIDTH-1:0]  operand;
    logic signed [I2Q2_WIDTH-1:0] product;
    logic                         sel_early, sel_prompt, sel_late;

`ifdef CHANNEL_HISTORY_SKIP_FIRST_EN
    logic primed_q;
`endif

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        capture   = 1'b0;
        square_en = 1'b0;
        absorb    = 1'b0;
        emit      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (acc_valid) begin
                    capture = 1'b1;
                    step_d  = 3'd0;
                    state_d = StSquare;
                end
            end
            StSquare: begin
                square_en = 1'b1;
                if (step_q == LastStep) begin
                    step_d  = 3'd0;
                    state_d = StValid;
`ifdef CHANNEL_HISTORY_SKIP_FIRST_EN
                    emit    = primed_q;
`else
                    emit    = 1'b1;
`endif
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            StValid: begin
`ifdef CHANNEL_HISTORY_SKIP_FIRST_EN
                // Priming epoch goes straight back to IDLE without involving tracking.
                state_d = primed_q ? StWait : StIdle;
`else
                state_d = StWait;
`endif
            end
            StWait: begin
                if (tracking_ready) begin
                    absorb  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Any sample arriving outside IDLE is discarded, including in the WAIT exit cycle.
        drop = acc_valid && (state_q != StIdle);
    end

    // State, step counter and status strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            step_q      <= 3'd0;
            busy        <= 1'b0;
            i2q2_valid  <= 1'b0;
            acc_dropped <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            busy        <= (state_d != StIdle);
            i2q2_valid  <= emit;
            acc_dropped <= drop;
        end
    end

`ifdef CHANNEL_HISTORY_SKIP_FIRST_EN
    // Primed once any epoch has completed squaring since reset
    always_ff @(posedge clk) begin
        if (reset) begin
            primed_q <= 1'b0;
        end else if (state_q == StValid) begin
            primed_q <= 1'b1;
        end
    end
`endif

    // Capture registers for the squarer operands
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_ie_q <= '0;
            cap_qe_q <= '0;
            cap_ip_q <= '0;
            cap_qp_q <= '0;
            cap_il_q <= '0;
            cap_ql_q <= '0;
        end else if (capture) begin
            cap_ie_q <= i_early;
            cap_qe_q <= q_early;
            cap_ip_q <= i_prompt;
            cap_qp_q <= q_prompt;
            cap_il_q <= i_late;
            cap_ql_q <= q_late;
        end
    end

    // Prompt history: shift k into k-1 on each accepted epoch
    always_ff @(posedge clk) begin
        if (reset) begin
            i_prompt_k   <= '0;
            q_prompt_k   <= '0;
            i_prompt_km1 <= '0;
            q_prompt_km1 <= '0;
        end else if (capture) begin
            i_prompt_km1 <= i_prompt_k;
            q_prompt_km1 <= q_prompt_k;
            i_prompt_k   <= i_prompt;
            q_prompt_k   <= q_prompt;
        end
    end

    // Operand select, step order IE, QE, IP, QP, IL, QL
    always_comb begin
        operand = '0;
        unique case (step_q)
            3'd0:    operand = cap_ie_q;
            3'd1:    operand = cap_qe_q;
            3'd2:    operand = cap_ip_q;
            3'd3:    operand = cap_qp_q;
            3'd4:    operand = cap_il_q;
            3'd5:    operand = cap_ql_q;
            default: operand = '0;
        endcase
        sel_early  = (step_q == 3'd0) || (step_q == 3'd1);
        sel_prompt = (step_q == 3'd2) || (step_q == 3'd3);
        sel_late   = (step_q == 3'd4) || (step_q == 3'd5);
    end

    // Signed square is never negative and at most 2^30, so the unsigned view is exact and two
    // of them sum to at most 2^31 without wrapping the accumulator.
    assign product = I2Q2_WIDTH'(operand) * I2Q2_WIDTH'(operand);

    // I^2+Q^2 accumulators; cleared on capture, held stable until the next capture
    always_ff @(posedge clk) begin
        if (reset) begin
            i2q2_early_k  <= '0;
            i2q2_prompt_k <= '0;
            i2q2_late_k   <= '0;
        end else if (capture) begin
            i2q2_early_k  <= '0;
            i2q2_prompt_k <= '0;
            i2q2_late_k   <= '0;
        end else if (square_en) begin
            if (sel_early) begin
                i2q2_early_k <= i2q2_early_k + $unsigned(product);
            end
            if (sel_prompt) begin
                i2q2_prompt_k <= i2q2_prompt_k + $unsigned(product);
            end
            if (sel_late) begin
                i2q2_late_k <= i2q2_late_k + $unsigned(product);
            end
        end
    end

    // Absorb tracking results as next epoch's history
    always_ff @(posedge clk) begin
        if (reset) begin
            iq_prompt_km1 <= '0;
            w_df_k        <= '0;
            w_df_dot_k    <= '0;
        end else if (absorb) begin
            iq_prompt_km1 <= iq_prompt_k_in;
            w_df_k        <= w_df_kp1;
            w_df_dot_k    <= w_df_dot_kp1;
        end
    end

endmodule

// File: tb/tb_channel_history.sv
// Directed, table-driven bench for channel_history. Also covers drop handling, reset during
// SQUARE and, when CHANNEL_HISTORY_SKIP_FIRST_EN is defined, the priming epoch.

module tb_channel_history;

    logic clk;
    logic reset;
    logic acc_valid;
    logic signed [15:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
    logic acc_dropped, busy, i2q2_valid;
    logic [31:0] i2q2_early_k, i2q2_prompt_k, i2q2_late_k;
    logic signed [15:0] i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1;
    logic [16:0] iq_prompt_km1;
    logic signed [26:0] w_df_k, w_df_dot_k;
    logic tracking_ready;
    logic [16:0] iq_prompt_k_in;
    logic signed [26:0] w_df_kp1, w_df_dot_kp1;

    channel_history dut (
        .clk           (clk),
        .reset         (reset),
        .acc_valid     (acc_valid),
        .i_early       (i_early),
        .q_early       (q_early),
        .i_prompt      (i_prompt),
        .q_prompt      (q_prompt),
        .i_late        (i_late),
        .q_late        (q_late),
        .acc_dropped   (acc_dropped),
        .busy          (busy),
        .i2q2_valid    (i2q2_valid),
        .i2q2_early_k  (i2q2_early_k),
        .i2q2_prompt_k (i2q2_prompt_k),
        .i2q2_late_k   (i2q2_late_k),
        .i_prompt_k    (i_prompt_k),
        .q_prompt_k    (q_prompt_k),
        .i_prompt_km1  (i_prompt_km1),
        .q_prompt_km1  (q_prompt_km1),
        .iq_prompt_km1 (iq_prompt_km1),
        .w_df_k        (w_df_k),
        .w_df_dot_k    (w_df_dot_k),
        .tracking_ready(tracking_ready),
        .iq_prompt_k_in(iq_prompt_k_in),
        .w_df_kp1      (w_df_kp1),
        .w_df_dot_kp1  (w_df_dot_kp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] ie, qe, ip, qp, il, ql;
        logic [31:0]        ee, ep, el;
        logic [16:0]        tiq;
        logic signed [26:0] twdf, twdd;
    } vec_t;

    vec_t vecs [4];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference history model
    longint m_ip, m_qp, m_iq, m_wdf, m_wdd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic signed [15:0] ie, qe, ip, qp, il, ql);
        i_early  = ie;
        q_early  = qe;
        i_prompt = ip;
        q_prompt = qp;
        i_late   = il;
        q_late   = ql;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, longint'(busy), 0);
        chk({name, "_valid"}, longint'(i2q2_valid), 0);
        chk({name, "_rest"}, longint'(|{acc_dropped, i2q2_early_k, i2q2_prompt_k, i2q2_late_k,
            i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1, iq_prompt_km1, w_df_k,
            w_df_dot_k}), 0);
    endtask

    // One accepted epoch followed by a tracking handshake
    task automatic run_epoch(input vec_t v, input string tag);
        int cyc;
        drive(v.ie, v.qe, v.ip, v.qp, v.il, v.ql);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        chk({tag, "_busy_c1"}, longint'(busy), 1);
        chk({tag, "_ip_k"}, longint'(i_prompt_k), longint'(v.ip));
        chk({tag, "_qp_k"}, longint'(q_prompt_k), longint'(v.qp));
        chk({tag, "_ip_km1"}, longint'(i_prompt_km1), m_ip);
        chk({tag, "_qp_km1"}, longint'(q_prompt_km1), m_qp);
        chk({tag, "_iq_km1"}, longint'(iq_prompt_km1), m_iq);
        chk({tag, "_wdf_k"}, longint'(w_df_k), m_wdf);
        chk({tag, "_wdd_k"}, longint'(w_df_dot_k), m_wdd);
        cyc = 1;
        while (!i2q2_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, longint'(cyc), 7);
        chk({tag, "_early"}, longint'(i2q2_early_k), longint'(v.ee));
        chk({tag, "_prompt"}, longint'(i2q2_prompt_k), longint'(v.ep));
        chk({tag, "_late"}, longint'(i2q2_late_k), longint'(v.el));
        tick();
        chk({tag, "_valid_1cyc"}, longint'(i2q2_valid), 0);
        chk({tag, "_busy_wait"}, longint'(busy), 1);
        tick();
        chk({tag, "_busy_stall"}, longint'(busy), 1);
        tracking_ready = 1'b1;
        iq_prompt_k_in = v.tiq;
        w_df_kp1       = v.twdf;
        w_df_dot_kp1   = v.twdd;
        tick();
        tracking_ready = 1'b0;
        chk({tag, "_busy_done"}, longint'(busy), 0);
        chk({tag, "_iq_abs"}, longint'(iq_prompt_km1), longint'(v.tiq));
        chk({tag, "_wdf_abs"}, longint'(w_df_k), longint'(v.twdf));
        chk({tag, "_wdd_abs"}, longint'(w_df_dot_k), longint'(v.twdd));
        chk({tag, "_prompt_hold"}, longint'(i2q2_prompt_k), longint'(v.ep));
        m_ip  = longint'(v.ip);
        m_qp  = longint'(v.qp);
        m_iq  = longint'(v.tiq);
        m_wdf = longint'(v.twdf);
        m_wdd = longint'(v.twdd);
    endtask

    // Priming epoch after reset; only meaningful with the skip-first build
    task automatic prime_epoch();
`ifdef CHANNEL_HISTORY_SKIP_FIRST_EN
        int pulses;
        pulses = 0;
        drive(16'sd1, 16'sd1, 16'sd11, -16'sd12, 16'sd1, 16'sd1);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        for (int c = 1; c < 8; c++) begin
            if (i2q2_valid) pulses++;
            chk("prime_busy", longint'(busy), 1);
            tick();
        end
        chk("prime_busy_drop", longint'(busy), 0);
        chk("prime_no_valid", longint'(pulses), 0);
        m_ip = 11;
        m_qp = -12;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0] = '{ie: 3, qe: 4, ip: -5, qp: 12, il: 0, ql: -1,
                    ee: 25, ep: 169, el: 1, tiq: 5, twdf: 1, twdd: 2};
        vecs[1] = '{ie: -32768, qe: -32768, ip: -32768, qp: -32768, il: -32768, ql: -32768,
                    ee: 32'h8000_0000, ep: 32'h8000_0000, el: 32'h8000_0000,
                    tiq: 9, twdf: -7, twdd: 4};
        vecs[2] = '{ie: 1, qe: -1, ip: 10, qp: 20, il: 100, ql: -200,
                    ee: 2, ep: 500, el: 50000, tiq: 22, twdf: 100, twdd: -3};
        vecs[3] = '{ie: 32767, qe: -32768, ip: 7, qp: 8, il: -1000, ql: 1000,
                    ee: 32'd2147418113, ep: 113, el: 2000000, tiq: 1, twdf: -1, twdd: 1};

        acc_valid      = 1'b0;
        tracking_ready = 1'b0;
        iq_prompt_k_in = '0;
        w_df_kp1       = '0;
        w_df_dot_kp1   = '0;
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        m_ip = 0; m_qp = 0; m_iq = 0; m_wdf = 0; m_wdd = 0;

        // Reset held together with strobes: reset must win
        reset = 1'b1;
        tick();
        acc_valid      = 1'b1;
        tracking_ready = 1'b1;
        drive(16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9);
        tick();
        reset          = 1'b0;
        acc_valid      = 1'b0;
        tracking_ready = 1'b0;
        chk_all_zero("reset");

        // Stray tracking_ready in IDLE is ignored
        tracking_ready = 1'b1;
        w_df_kp1       = 27'sd55;
        tick();
        tracking_ready = 1'b0;
        chk("idle_trk_busy", longint'(busy), 0);
        chk("idle_trk_wdf", longint'(w_df_k), 0);

        prime_epoch();
        for (int i = 0; i < 4; i++) begin
            run_epoch(vecs[i], $sformatf("vec%0d", i));
        end

        // acc_valid during SQUARE is dropped
        drive(16'sd2, 16'sd2, -16'sd3, 16'sd4, 16'sd6, 16'sd8);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        tick();
        drive(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        chk("drop_sq_pulse", longint'(acc_dropped), 1);
        tick();
        chk("drop_sq_once", longint'(acc_dropped), 0);
        chk("drop_sq_ip_k", longint'(i_prompt_k), -3);
        chk("drop_sq_ip_km1", longint'(i_prompt_km1), m_ip);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (i2q2_valid) pulses++;
            tick();
        end
        chk("drop_sq_pulses", longint'(pulses), 1);
        chk("drop_sq_early", longint'(i2q2_early_k), 8);
        chk("drop_sq_prompt", longint'(i2q2_prompt_k), 25);
        chk("drop_sq_late", longint'(i2q2_late_k), 100);

        // acc_valid in the same cycle as tracking_ready: tracking wins, sample dropped
        drive(16'sd555, 16'sd555, 16'sd555, 16'sd555, 16'sd555, 16'sd555);
        acc_valid      = 1'b1;
        tracking_ready = 1'b1;
        iq_prompt_k_in = 17'd33;
        w_df_kp1       = -27'sd50;
        w_df_dot_kp1   = 27'sd6;
        tick();
        acc_valid      = 1'b0;
        tracking_ready = 1'b0;
        chk("drop_wt_pulse", longint'(acc_dropped), 1);
        chk("drop_wt_busy", longint'(busy), 0);
        chk("drop_wt_ip_k", longint'(i_prompt_k), -3);
        chk("drop_wt_qp_km1", longint'(q_prompt_km1), m_qp);
        chk("drop_wt_wdf", longint'(w_df_k), -50);
        tick();
        chk("drop_wt_once", longint'(acc_dropped), 0);
        chk("drop_wt_idle", longint'(busy), 0);
        chk("drop_wt_novalid", longint'(i2q2_valid), 0);
        chk("drop_wt_prompt", longint'(i2q2_prompt_k), 25);

        // Reset during SQUARE step 3
        drive(16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd5);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("rst_mid");
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (i2q2_valid || busy) pulses++;
            tick();
        end
        chk("rst_mid_quiet", longint'(pulses), 0);
        m_ip = 0; m_qp = 0; m_iq = 0; m_wdf = 0; m_wdd = 0;
        prime_epoch();
        run_epoch(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_history.md
Name: channel_history

Overview:
- Per-channel history/pre-processing stage directly upstream of the tracking loops.
- Captures one epoch of signed E/P/L I/Q accumulations and computes I²+Q² for early, prompt and late with one shared sequential multiplier.
- Presents the k / k-1 prompt history and the loop-filter state to the tracking loops, then absorbs the tracking results (prompt IQ magnitude, w_df, w_df_dot) as next epoch's history.

Parameters:
- ACC_WIDTH, 16, signed accumulator width; derived localparam I2Q2_WIDTH = 2*ACC_WIDTH.
- IQ_WIDTH, 17, unsigned prompt IQ magnitude width.
- W_DF_WIDTH, 27, FLL frequency state width (signed).
- W_DF_DOT_WIDTH, 27, FLL frequency-rate state width (signed).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- acc_valid  in  1  one-cycle strobe, epoch accumulations valid
- i_early, q_early, i_prompt, q_prompt, i_late, q_late  in  ACC_WIDTH each  signed accumulations
- acc_dropped  out  1  one-cycle pulse, acc_valid rejected
- busy  out  1  high whenever state != IDLE
- i2q2_valid  out  1  one-cycle strobe to tracking loops
- i2q2_early_k, i2q2_prompt_k, i2q2_late_k  out  I2Q2_WIDTH each  unsigned I²+Q²
- i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1  out  ACC_WIDTH each  prompt history
- iq_prompt_km1  out  IQ_WIDTH  previous epoch prompt magnitude
- w_df_k  out  W_DF_WIDTH  current FLL state
- w_df_dot_k  out  W_DF_DOT_WIDTH  current FLL rate state
- tracking_ready  in  1  one-cycle strobe, tracking results valid
- iq_prompt_k_in  in  IQ_WIDTH  prompt magnitude returned by tracking
- w_df_kp1  in  W_DF_WIDTH  updated FLL state
- w_df_dot_kp1  in  W_DF_DOT_WIDTH  updated FLL rate state

Behaviour:
- Interface: one clock, clk. Reset, named reset, is synchronous and active-high. All outputs are registered.
- Reset values: every output 0; state IDLE; primed flag 0.
- States: IDLE, SQUARE, VALID, WAIT.
- IDLE + acc_valid:
  - Latch all six inputs into capture registers.
  - i_prompt_km1/q_prompt_km1 <= old i_prompt_k/q_prompt_k.
  - i_prompt_k/q_prompt_k <= new prompt values.
  - Clear all three i2q2 accumulators; step counter <= 0; go to SQUARE.
- SQUARE: 6 cycles, step 0..5 in order IE, QE, IP, QP, IL, QL.
  - Each step adds operand² to its pair's accumulator.
  - Square is computed as a signed product and is unsigned, 2*ACC_WIDTH-1 bits.
  - Sums do not overflow: (-2^15)² + (-2^15)² = 2^31 fits in 32 bits.
  - After step 5, go to VALID.
- VALID: i2q2_valid = 1 for exactly one cycle; primed <= 1; go to WAIT.
- Latency: acc_valid sampled in cycle 0 -> i2q2_valid high in cycle 7. i2q2_* outputs stay stable from cycle 7 until the next capture.
- WAIT + tracking_ready:
  - iq_prompt_km1 <= iq_prompt_k_in; w_df_k <= w_df_kp1; w_df_dot_k <= w_df_dot_kp1.
  - Go to IDLE; busy falls the next cycle.
- tracking_ready outside WAIT: ignored, no state change.
- acc_valid while state != IDLE, including WAIT coinciding with tracking_ready:
  - Sample discarded; acc_dropped pulses the next cycle.
  - Capture registers and history unchanged.
- Simultaneous reset with any strobe: reset wins.
- Reset mid-SQUARE or mid-WAIT: immediate return to IDLE with all-zero outputs; no i2q2_valid emitted.
- Stall: WAIT has no timeout. The channel stays busy until tracking_ready arrives or reset.

Optional Feature:
- Macro: CHANNEL_HISTORY_SKIP_FIRST_EN.
- Defined:
  - The first epoch after reset (primed=0) runs capture and SQUARE but suppresses i2q2_valid.
  - It sets primed=1 and returns directly from VALID to IDLE, so k-1 history is valid before the first tracking run.
  - Subsequent epochs behave normally.
- Undefined: every accepted epoch emits i2q2_valid, with zero km1 history on the first epoch.

Test Plan:
- Magnitude and latency:
  - Stimulus: reset, then acc_valid with IE=3, QE=4, IP=-5, QP=12, IL=0, QL=-1.
  - Required: i2q2_valid exactly 7 cycles later with early=25, prompt=169, late=1; busy high from cycle 1.
- Extreme values:
  - Stimulus: all six inputs = -32768.
  - Required: each i2q2 = 0x80000000, no wrap.
- History shift:
  - Stimulus: epoch 1 IP=10, QP=20; tracking_ready with iq_prompt_k_in=22, w_df_kp1=100, w_df_dot_kp1=-3; then epoch 2 IP=7, QP=8.
  - Required during epoch 2: i_prompt_km1=10, q_prompt_km1=20, i_prompt_k=7, q_prompt_k=8, iq_prompt_km1=22, w_df_k=100, w_df_dot_k=-3.
- Drop handling:
  - Stimulus: acc_valid during SQUARE, and acc_valid in the same cycle as tracking_ready.
  - Required: acc_dropped pulses once per occurrence; captured values unchanged; no extra i2q2_valid.
- Reset mid-operation:
  - Stimulus: reset during SQUARE step 3.
  - Required: next cycle all outputs 0, busy=0, no i2q2_valid; a subsequent epoch completes normally.
- With CHANNEL_HISTORY_SKIP_FIRST_EN defined:
  - Stimulus: first epoch after reset.
  - Required: no i2q2_valid, busy drops after 8 cycles; second epoch emits i2q2_valid with correct km1 history.
